// File: rtl/modctr.sv
// modctr: parametrised up/down modulo counter with synchronous load,
// one-shot stop mode, registered wrap/done flags and a terminal-count flag.
// Optional built-in prescaler enabled by defining MODCTR_PRESCALE_EN; when it
// is undefined no prescaler logic is built and tick_o is tied high.
module modctr #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIV   = 100
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             e_i,
  input  logic             dir_i,
  input  logic [WIDTH-1:0] max_i,
  input  logic             ld_i,
  input  logic [WIDTH-1:0] d_i,
  input  logic             oneshot_i,
  output logic [WIDTH-1:0] q_o,
  output logic             tc_o,
  output logic             wrap_o,
  output logic             done_o,
  output logic             tick_o
);

  logic [WIDTH-1:0] q_q, q_d;
  logic             wrap_q, wrap_d;
  logic             done_q, done_d;
  logic             en_c;
  logic             term_c;

`ifdef MODCTR_PRESCALE_EN
  localparam int unsigned PsW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PsW-1:0] PsLast = PsW'(DIV - 1);

  logic [PsW-1:0] ps_q, ps_d;

  // Free-running prescaler: 0..DIV-1, independent of enable, load and done.
  always_comb begin
    ps_d = ps_q + PsW'(1);
    if (ps_q == PsLast) begin
      ps_d = '0;
    end
  end

  // Prescaler state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ps_q <= '0;
    end else begin
      ps_q <= ps_d;
    end
  end

  // Reset gating keeps the strobe low in reset even when DIV=1.
  assign tick_o = rst_ni & (ps_q == PsLast);
`else
  // No prescaler: the strobe is permanently asserted (DIV is illegal below 1).
  assign tick_o = (DIV != 0);
`endif

  assign en_c = e_i & tick_o;

  // Terminal value for the current direction; up treats anything above max as terminal.
  assign term_c = dir_i ? (q_q >= max_i) : (q_q == '0);

  // Next count / flags: load > done freeze > counting.
  always_comb begin
    q_d    = q_q;
    wrap_d = 1'b0;
    done_d = done_q;
    if (ld_i) begin
      q_d    = (d_i > max_i) ? max_i : d_i;
      done_d = 1'b0;
    end else if (done_q) begin
      // Frozen; leaving one-shot mode releases the freeze without counting.
      if (!oneshot_i) begin
        done_d = 1'b0;
      end
    end else if (en_c) begin
      if (term_c && oneshot_i) begin
        done_d = 1'b1;
      end else if (dir_i) begin
        if (term_c) begin
          q_d    = '0;
          wrap_d = 1'b1;
        end else begin
          q_d = q_q + WIDTH'(1);
        end
      end else begin
        if (q_q > max_i) begin
          // Max was lowered below the count: snap into range, not a wrap.
          q_d = max_i;
        end else if (term_c) begin
          q_d    = max_i;
          wrap_d = 1'b1;
        end else begin
          q_d = q_q - WIDTH'(1);
        end
      end
    end
  end

  // Counter and flag registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_q    <= '0;
      wrap_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
      done_q <= done_d;
    end
  end

  assign q_o    = q_q;
  assign wrap_o = wrap_q;
  assign done_o = done_q;
  assign tc_o   = dir_i ? (q_q == max_i) : (q_q == '0);

endmodule

// File: tb/tb_modctr.sv
// Self-checking bench for modctr: directed scenarios plus randomized stimulus
// against an arithmetic reference model of the counter.
module tb_modctr;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned DIV   = 100;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             e = 1'b0;
  logic             dir = 1'b0;
  logic [WIDTH-1:0] max_v = '0;
  logic             ld = 1'b0;
  logic [WIDTH-1:0] d = '0;
  logic             oneshot = 1'b0;
  logic [WIDTH-1:0] q;
  logic             tc, wrap, done, tick;

  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  int m_q = 0;
  int m_ps = 0;
  bit m_done = 1'b0;
  bit m_wrap = 1'b0;

  modctr #(.WIDTH(WIDTH), .DIV(DIV)) dut (
    .clk_i(clk), .rst_ni(rst_n), .e_i(e), .dir_i(dir), .max_i(max_v),
    .ld_i(ld), .d_i(d), .oneshot_i(oneshot), .q_o(q), .tc_o(tc),
    .wrap_o(wrap), .done_o(done), .tick_o(tick)
  );

  always #5 clk = ~clk;

  function automatic bit model_tick();
`ifdef MODCTR_PRESCALE_EN
    return (m_ps == int'(DIV) - 1);
`else
    return 1'b1;
`endif
  endfunction

  // Advance the model by one edge using the currently driven inputs.
  task automatic model_edge();
    int mx, qc;
    bit en, term;
    mx = int'(max_v);
    en = e && model_tick();
    m_ps = (m_ps + 1) % int'(DIV);
    m_wrap = 1'b0;
    if (ld) begin
      m_q = (int'(d) > mx) ? mx : int'(d);
      m_done = 1'b0;
    end else if (m_done) begin
      if (!oneshot) m_done = 1'b0;
    end else if (en) begin
      term = dir ? (m_q >= mx) : (m_q == 0);
      if (term && oneshot) m_done = 1'b1;
      else if (!dir && m_q > mx) m_q = mx;
      else begin
        qc = (m_q < mx) ? m_q : mx;
        m_q = dir ? (qc + 1) % (mx + 1) : (qc + mx) % (mx + 1);
        m_wrap = term;
      end
    end
  endtask

  task automatic clk_step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    m_q = 0; m_ps = 0; m_done = 1'b0; m_wrap = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    bit exp_tick;
`ifdef MODCTR_PRESCALE_EN
    exp_tick = 1'b0;
`else
    exp_tick = 1'b1;
`endif
    rst_n = 1'b0;
    #3;
    n_cmp++; if (q !== 8'd0) begin n_err++; $display("FAIL reset_q got %0d want 0", q); end
    n_cmp++; if (wrap !== 1'b0) begin n_err++; $display("FAIL reset_wrap got %b want 0", wrap); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", done); end
    n_cmp++; if (tick !== exp_tick) begin n_err++; $display("FAIL reset_tick got %b want %b", tick, exp_tick); end
    n_cmp++; if (tc !== 1'b1) begin n_err++; $display("FAIL reset_tc got %b want 1", tc); end
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_up_wrap();
    int eq;
    max_v = 8'd49; dir = 1'b1; e = 1'b1; ld = 1'b0; oneshot = 1'b0;
    do_reset();
    for (int k = 1; k <= 60; k++) begin
      clk_step();
      eq = k % 50;
      n_cmp++; if (q !== 8'(eq)) begin n_err++; $display("FAIL up_q edge %0d got %0d want %0d", k, q, eq); end
      n_cmp++; if (wrap !== (k == 50)) begin n_err++; $display("FAIL up_wrap edge %0d got %b want %b", k, wrap, (k == 50)); end
      n_cmp++; if (tc !== (eq == 49)) begin n_err++; $display("FAIL up_tc edge %0d got %b want %b", k, tc, (eq == 49)); end
    end
  endtask

  task automatic test_down_wrap();
    int exp_q[5] = '{2, 1, 0, 5, 4};
    max_v = 8'd5; dir = 1'b0; e = 1'b1; oneshot = 1'b0;
    ld = 1'b1; d = 8'd2;
    for (int i = 0; i < 5; i++) begin
      clk_step();
      ld = 1'b0;
      n_cmp++; if (q !== 8'(exp_q[i])) begin n_err++; $display("FAIL down_q step %0d got %0d want %0d", i, q, exp_q[i]); end
      n_cmp++; if (wrap !== (i == 3)) begin n_err++; $display("FAIL down_wrap step %0d got %b want %b", i, wrap, (i == 3)); end
    end
  endtask

  task automatic test_load_clamp();
    max_v = 8'd10; dir = 1'b1; e = 1'b1; oneshot = 1'b0;
    ld = 1'b1; d = 8'd200;
    clk_step();
    ld = 1'b0;
    n_cmp++; if (q !== 8'd10) begin n_err++; $display("FAIL clamp_q got %0d want 10", q); end
    n_cmp++; if (wrap !== 1'b0) begin n_err++; $display("FAIL clamp_wrap got %b want 0", wrap); end
    clk_step();
    n_cmp++; if (q !== 8'd0) begin n_err++; $display("FAIL clamp_next_q got %0d want 0", q); end
    n_cmp++; if (wrap !== 1'b1) begin n_err++; $display("FAIL clamp_next_wrap got %b want 1", wrap); end
  endtask

  task automatic test_oneshot();
    oneshot = 1'b1; dir = 1'b1; max_v = 8'd3; e = 1'b1;
    ld = 1'b1; d = 8'd0;
    clk_step();
    ld = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      clk_step();
      n_cmp++; if (q !== 8'(i) || done !== 1'b0) begin n_err++; $display("FAIL oneshot_run got q=%0d done=%b want q=%0d done=0", q, done, i); end
    end
    for (int i = 0; i < 12; i++) begin
      clk_step();
      n_cmp++;
      if (q !== 8'd3 || done !== 1'b1 || wrap !== 1'b0) begin
        n_err++; $display("FAIL oneshot_hold cyc %0d got q=%0d done=%b wrap=%b want q=3 done=1 wrap=0", i, q, done, wrap);
      end
    end
    ld = 1'b1; d = 8'd0;
    clk_step();
    ld = 1'b0;
    n_cmp++; if (q !== 8'd0 || done !== 1'b0) begin n_err++; $display("FAIL oneshot_reload got q=%0d done=%b want q=0 done=0", q, done); end
  endtask

  task automatic test_async_reset();
    oneshot = 1'b1; dir = 1'b1; max_v = 8'd7; e = 1'b1;
    ld = 1'b1; d = 8'd7;
    clk_step();
    ld = 1'b0;
    clk_step();
    n_cmp++; if (q !== 8'd7 || done !== 1'b1) begin n_err++; $display("FAIL arst_setup got q=%0d done=%b want q=7 done=1", q, done); end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (q !== 8'd0 || done !== 1'b0 || wrap !== 1'b0) begin
      n_err++; $display("FAIL arst_clear got q=%0d done=%b wrap=%b want 0/0/0", q, done, wrap);
    end
    model_clear();
    oneshot = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    int sel;
    bit exp_tc;
    do_reset();
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        sel = int'($urandom_range(0, 4));
        case (sel)
          0: max_v = 8'd0;
          1: max_v = 8'd1;
          2: max_v = 8'hFF;
          default: max_v = 8'($urandom_range(2, 20));
        endcase
      end
      if ($urandom_range(0, 7) == 0) dir = 1'($urandom);
      if ($urandom_range(0, 24) == 0) oneshot = 1'($urandom);
      e = ($urandom_range(0, 3) != 0);
      ld = ($urandom_range(0, 19) == 0);
      d = 8'($urandom);
      clk_step();
      exp_tc = dir ? (m_q == int'(max_v)) : (m_q == 0);
      n_cmp++;
      if (q !== 8'(m_q) || wrap !== m_wrap || done !== m_done || tc !== exp_tc || tick !== model_tick()) begin
        n_err++;
        $display("FAIL random cyc %0d got q=%0d wrap=%b done=%b tc=%b tick=%b want q=%0d wrap=%b done=%b tc=%b tick=%b",
                 i, q, wrap, done, tc, tick, m_q, m_wrap, m_done, exp_tc, model_tick());
      end
    end
    ld = 1'b0; oneshot = 1'b0;
  endtask

`ifdef MODCTR_PRESCALE_EN
  task automatic test_prescale();
    int ticks = 0;
    int last_wrap = -1;
    int n_wraps = 0;
    e = 1'b1; max_v = 8'd9; dir = 1'b1; oneshot = 1'b0; ld = 1'b0;
    do_reset();
    for (int c = 0; c < 2100; c++) begin
      if (tick) ticks++;
      clk_step();
      n_cmp++;
      if (q !== 8'(m_q) || wrap !== m_wrap || tick !== model_tick()) begin
        n_err++; $display("FAIL prescale cyc %0d got q=%0d wrap=%b tick=%b want q=%0d wrap=%b tick=%b", c, q, wrap, tick, m_q, m_wrap, model_tick());
      end
      if (wrap) begin
        if (last_wrap >= 0) begin
          n_cmp++;
          if (c - last_wrap != 1000) begin n_err++; $display("FAIL prescale_wrap_period got %0d want 1000", c - last_wrap); end
        end
        last_wrap = c;
        n_wraps++;
      end
    end
    n_cmp++; if (ticks != 21) begin n_err++; $display("FAIL prescale_tick_count got %0d want 21", ticks); end
    n_cmp++; if (n_wraps != 2) begin n_err++; $display("FAIL prescale_wrap_count got %0d want 2", n_wraps); end
  endtask
`endif

  initial begin
    test_reset();
`ifdef MODCTR_PRESCALE_EN
    test_prescale();
`else
    test_up_wrap();
    test_down_wrap();
    test_load_clamp();
    test_oneshot();
    test_async_reset();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
